// File: rtl/adc128_spi_ctrl.sv
// SPI master for the ADC128S022: one start_cnv runs one (or, with ADC_DUAL_FRAME_EN,
// two back-to-back) 16-bit frames and returns the 12-bit code with a level cnv_complete.
module adc128_spi_ctrl #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  channel,
    input  logic        start_cnv,
    output logic [11:0] result,
    output logic        cnv_complete,
    input  logic        MISO,
    output logic        MOSI,
    output logic        SCLK,
    output logic        SS_n
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(SCLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            phase_hi;
    logic [3:0]      bit_cnt;
    logic [2:0]      ch_q;
    logic [11:0]     shift_q;
    logic [15:0]     frame_word;
    logic            half_end;
`ifdef ADC_DUAL_FRAME_EN
    logic            second;
`endif

    assign half_end   = (cnt == HALF_LAST);
    assign frame_word = {2'b00, ch_q, 11'd0};

    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_cnv) state_nxt = LEAD;
            LEAD:  if (half_end) state_nxt = SHIFT;
            SHIFT: if (half_end && phase_hi && bit_cnt == 4'd15) state_nxt = TRAIL;
            TRAIL: if (half_end) begin
`ifdef ADC_DUAL_FRAME_EN
                state_nxt = second ? DONE : GAP;
`else
                state_nxt = DONE;
`endif
            end
            GAP:   if (cnt == GAP_LAST) state_nxt = LEAD;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            phase_hi <= 1'b0;
            bit_cnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt      <= '0;
                phase_hi <= 1'b0;
                bit_cnt  <= 4'd0;
            end else if (state == SHIFT && half_end) begin
                cnt      <= '0;
                phase_hi <= ~phase_hi;
                if (phase_hi) bit_cnt <= bit_cnt + 4'd1;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Pins are registered decodes of the state, so they lag the state by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n         <= 1'b1;
            SCLK         <= 1'b1;
            MOSI         <= 1'b0;
            ch_q         <= 3'd0;
            shift_q      <= 12'd0;
            result       <= 12'd0;
            cnv_complete <= 1'b0;
`ifdef ADC_DUAL_FRAME_EN
            second       <= 1'b0;
`endif
        end else begin
            SS_n <= !(state inside {LEAD, SHIFT, TRAIL});
            SCLK <= !(state == SHIFT && !phase_hi);
            MOSI <= (state == SHIFT) ? frame_word[4'd15 - bit_cnt] : 1'b0;
            if (state == IDLE && start_cnv) begin
                ch_q         <= channel;
                cnv_complete <= 1'b0;
`ifdef ADC_DUAL_FRAME_EN
                second       <= 1'b0;
`endif
            end
            // Only the last 12 of the 16 captured bits survive; the leading 4 fall off.
            if (state == SHIFT && phase_hi && cnt == '0)
                shift_q <= {shift_q[10:0], MISO};
`ifdef ADC_DUAL_FRAME_EN
            if (state == TRAIL && half_end) second <= 1'b1;
`endif
            if (state == DONE) begin
                result       <= shift_q;
                cnv_complete <= 1'b1;
            end
        end
    end

endmodule

// File: doc/adc128_spi_ctrl.md
# adc128_spi_ctrl

SPI master for the ADC128S022 8-channel 12-bit ADC. It sits between the pot round-robin sequencer and the ADC pins. On each `start_cnv` it runs one complete SPI conversion for the requested channel and returns the 12-bit code with a level-type `cnv_complete`. It owns SCLK generation, SS_n framing, MOSI address shifting and MISO capture.

## Interface
Parameters:
- `SCLK_DIV`, default 32: clk cycles per SCLK period. Must be even and ≥ 4. Half period `H = SCLK_DIV/2`.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `channel`  in  3  ADC channel address; sampled on the cycle `start_cnv` is accepted
- `start_cnv`  in  1  conversion request; honoured only in IDLE
- `result`  out  12  last converted code; holds between conversions
- `cnv_complete`  out  1  level; high from end of conversion until the next accepted `start_cnv`
- `MISO`  in  1  ADC DOUT
- `MOSI`  out  1  ADC DIN
- `SCLK`  out  1  serial clock; idles high
- `SS_n`  out  1  ADC chip select, active-low

## Operation
- States:
  - IDLE: SS_n=1, SCLK=1.
  - LEAD: SS_n=0, SCLK=1, lasts H clk.
  - SHIFT: 16 SCLK periods. Each period is H clk with SCLK low, then H clk with SCLK high.
  - TRAIL: SS_n=0, SCLK=1, lasts H clk.
  - GAP: SS_n=1, lasts SCLK_DIV clk; used in dual-frame mode only.
  - DONE: returns to IDLE in the same cycle and sets `cnv_complete`.
- Accept rule: `start_cnv`=1 in IDLE latches `channel`, clears `cnv_complete` and moves to LEAD. `start_cnv` in any other state is ignored.
- Frame word, MSB first: bits[15:14]=0, bits[13:11]=latched channel, bits[10:0]=0.
- MOSI changes on the clk cycle SCLK is driven low (falling edge). Bit 15 appears at the first fall.
- MISO is sampled into a 16-bit shift register on the clk cycle SCLK is driven high (rising edge).
- After the 16th rise, `result` is loaded with shift[11:0]. The leading 4 bits are discarded and not checked.
- MOSI is 0 whenever SS_n=1 or outside SHIFT.
- Bit and half-period counters reset at each frame start. No wrap carries between frames.

## Timing
- Reset values: SS_n=1, SCLK=1, MOSI=0, `result`=12'h000, `cnv_complete`=0, state=IDLE.
- `start_cnv` sampled at edge N puts SS_n low after edge N+1.
- Single frame: `cnv_complete` rises 17·SCLK_DIV+1 clk after the accepting edge. That is 545 clk at the default.
- Dual frame: `cnv_complete` rises 35·SCLK_DIV+1 clk after the accepting edge. That is 1121 clk at the default.
- `result` and `cnv_complete` update on the same edge. `result` is never glitched mid-conversion.
- `start_cnv` on the same cycle that `cnv_complete` rises is ignored (state is not IDLE). It is accepted from the next cycle.
- `start_cnv` held high continuously: a new conversion starts on the first IDLE cycle. `cnv_complete` is then high for exactly 1 clk.
- `channel` changes after acceptance have no effect on the running conversion.
- Asynchronous reset mid-frame forces all outputs to reset values immediately and aborts the frame. No partial `result` is written.

## Configuration
- `ADC_DUAL_FRAME_EN` defined: each accepted request runs frame 1, then GAP, then frame 2. Both frames carry the same address. `result` comes from frame 2 only, so it always belongs to the requested channel.
- `ADC_DUAL_FRAME_EN` undefined: one frame per request. `result` is the code for the channel addressed in the previous request (ADC pipeline). After reset, the first result is channel 0.

## Test plan
- Channel 3 request, ADC model drives 12'hA5C for ch3, dual mode -> MOSI frame 16'h1800, 16 SCLK pulses per frame, `result`=12'hA5C, `cnv_complete` high at clk 1121.
- Single-frame build, requests ch1 then ch5, model codes ch1=12'h111, ch5=12'h555 -> results 12'h000 (ch0 pipeline), then 12'h111.
- `start_cnv` pulsed again mid-SHIFT with channel=7 -> ignored. Frame word and latency unchanged, and ch7 is never addressed.
- `start_cnv` held high for three conversions -> back-to-back frames, `cnv_complete` 1-clk pulses, SS_n high for ≥ 1 clk between frames.
- Reset asserted during bit 8 -> SS_n=1, SCLK=1, MOSI=0, `result`=0 with no clk edge. After release, the next request completes normally.
- SCLK_DIV=4 build -> SCLK 2 clk low / 2 clk high, latency 69 clk (single frame) and 141 clk (dual).
